branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Bimodal direction predictor in the IF stage, plus resolution logic at EX/MEM.
//  Supplies c_guess for the instruction being fetched, and carries that guess down the pipeline.
//  At EX/MEM it compares the guess with the resolved outcome and drives hit, em_type and em_guess.
//  These three outputs go to the next-PC selector.
//  Trains a table of 2-bit saturating counters and keeps branch/mispredict performance counters.
// PARAMETERS
//  IDX_W      4      table index width; 2**IDX_W counters indexed by pc[IDX_W+1:2]
//  CNT_INIT   2'b01  counter reset value (weakly not-taken)
//  PIPE_DEPTH 2      guess register stages between IF and EX/MEM (IF/ID, ID/EX)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst_n        in   1   synchronous active-low reset
//  stall        in   1   hold all guess pipeline registers
//  flush        in   1   squash guess pipeline registers (wrong-path instructions)
//  if_pc        in   32  PC of instruction in IF
//  c_guess      out  1   predicted direction for if_pc (1 = taken)
//  em_valid     in   1   EX/MEM holds a valid instruction
//  em_is_branch in   1   EX/MEM instruction is a conditional branch
//  em_is_jalr   in   1   EX/MEM instruction is JALR
//  em_pc        in   32  PC of EX/MEM instruction
//  em_taken     in   1   resolved branch outcome from ALU compare
//  em_guess     out  1   recovery direction: 1 = redirect to em_baddr, 0 = em_pc+4
//  hit          out  1   1 = no redirect needed (prediction correct or not a branch)
//  em_type      out  2   0 = other, 1 = jalr, 2 = branch
//  br_count     out  32  resolved conditional branches since reset
//  miss_count   out  32  mispredicted conditional branches since reset
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all table entries = CNT_INIT; guess pipe = 0; br_count = miss_count = 0.
//    Combinational outputs then follow their inputs. Reset mid-training discards all history.
//  - Lookup: c_guess = table[if_pc[IDX_W+1:2]][1]. Combinational, same cycle, no bubble.
//    c_guess is valid for any if_pc; the consumer qualifies it with opcode.
//  - Guess pipe: PIPE_DEPTH registers carry c_guess into pred_em.
//    flush=1 zeroes every stage and has priority over stall.
//    stall=1 (no flush) holds all stages. Otherwise the pipe shifts one stage per cycle.
//  - em_type: em_valid&em_is_jalr -> 1; em_valid&em_is_branch -> 2; else 0.
//    JALR and branch both asserted is illegal; JALR wins.
//  - hit = (em_type!=2) | (pred_em==em_taken). em_guess = em_taken (resolved direction).
//  - Training: at an edge where em_type==2 and stall==0, update the entry at em_pc[IDX_W+1:2].
//    Taken increments saturating at 3; not-taken decrements saturating at 0.
//  - Counter to prediction map: 00/01 -> not-taken, 10/11 -> taken.
//  - Same-cycle read and write of one index: c_guess returns the pre-update value (no bypass).
//    The new value is visible next cycle.
//  - Perf: at each training edge br_count+=1, and miss_count+=1 if !hit.
//    Both saturate at 32'hFFFF_FFFF, no wrap.
//  - Only em_type, hit and em_guess are combinational from EX/MEM inputs.
//    No combinational path from EX/MEM inputs to c_guess.
// TESTING
//  1 Reset then if_pc=0x40 -> c_guess=0; br_count=miss_count=0; em_type=0, hit=1.
//  2 Branch at pc 0x40 resolved taken twice (em_type=2, stall=0):
//    counter 01->10->11. Next lookup of 0x40 -> c_guess=1. Aliasing pc 0x80 (IDX_W=4) -> also 1.
//  3 Guess pipe: c_guess=1 at IF, no stall -> pred_em=1 two cycles later.
//    em_taken=0 -> hit=0, em_guess=0, miss_count+1.
//  4 stall=1 for 3 cycles -> pipe and table unchanged.
//    flush=1 together with stall=1 -> pipe zeroed at next edge.
//  5 Saturation: counter at 11, 5 more taken -> stays 11.
//    Then 4 not-taken -> 10,01,00,00, and c_guess flips to 0 after the 2nd not-taken.
//  6 em_is_jalr=1 -> em_type=1, hit=1, no training.
//    Reset asserted mid-sequence after case 2 -> entry back to 01, counters 0.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal IF-stage direction predictor with EX/MEM resolution, training and perf counters
module branch_predictor #(
  parameter int          IDX_W      = 4,
  parameter logic [1:0]  CNT_INIT   = 2'b01,
  parameter int          PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] if_pc,
  output logic        c_guess,
  input  logic        em_valid,
  input  logic        em_is_branch,
  input  logic        em_is_jalr,
  input  logic [31:0] em_pc,
  input  logic        em_taken,
  output logic        em_guess,
  output logic        hit,
  output logic [1:0]  em_type,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);
  logic [1:0]            tbl [2**IDX_W];
  logic [PIPE_DEPTH-1:0] pipe;
  logic [PIPE_DEPTH:0]   shifted;
  logic [IDX_W-1:0]      ri, wi;
  logic [1:0]            cur, nxt;
  logic                  pred_em, train;
  always_comb begin
    ri       = if_pc[IDX_W+1:2];
    wi       = em_pc[IDX_W+1:2];
    c_guess  = tbl[ri][1];
    shifted  = {pipe, c_guess};
    pred_em  = pipe[PIPE_DEPTH-1];
    em_type  = (em_valid && em_is_jalr) ? 2'd1 : (em_valid && em_is_branch) ? 2'd2 : 2'd0;
    hit      = (em_type != 2'd2) || (pred_em == em_taken);
    em_guess = em_taken;
    train    = (em_type == 2'd2) && !stall;
    cur      = tbl[wi];
    nxt      = em_taken ? ((cur == 2'b11) ? cur : cur + 2'd1) : ((cur == 2'b00) ? cur : cur - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= CNT_INIT;
      pipe       <= '0;
      br_count   <= '0;
      miss_count <= '0;
    end else begin
      if (flush) pipe <= '0;
      else if (!stall) pipe <= shifted[PIPE_DEPTH-1:0];
      if (train) begin
        tbl[wi]  <= nxt;
        br_count <= (br_count == 32'hFFFF_FFFF) ? br_count : br_count + 32'd1;
        if (!hit) miss_count <= (miss_count == 32'hFFFF_FFFF) ? miss_count : miss_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor
module tb_branch_predictor;
  logic        clk = 0, rst_n, stall, flush, c_guess, em_valid, em_is_branch, em_is_jalr, em_taken, em_guess, hit;
  logic [31:0] if_pc, em_pc, br_count, miss_count;
  logic [1:0]  em_type;
  int checks = 0, errors = 0;
  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .if_pc(if_pc), .c_guess(c_guess),
    .em_valid(em_valid), .em_is_branch(em_is_branch), .em_is_jalr(em_is_jalr), .em_pc(em_pc),
    .em_taken(em_taken), .em_guess(em_guess), .hit(hit), .em_type(em_type),
    .br_count(br_count), .miss_count(miss_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic em(input logic v, input logic br, input logic jr, input logic [31:0] pc, input logic tk);
    em_valid = v; em_is_branch = br; em_is_jalr = jr; em_pc = pc; em_taken = tk;
  endtask
  initial begin
    rst_n = 0; stall = 0; flush = 0; if_pc = 0;
    em(0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1;
    if_pc = 32'h40; #1;
    check("rst_guess", c_guess, 0);
    check("rst_br", br_count, 0);
    check("rst_miss", miss_count, 0);
    check("rst_type", em_type, 0);
    check("rst_hit", hit, 1);
    em(1, 1, 0, 32'h40, 1); #1;
    check("br_type", em_type, 2);
    check("br_hit_pre", hit, 0);
    tick();
    check("one_taken_guess", c_guess, 1);
    tick();
    em(0, 0, 0, 0, 0); #1;
    check("two_taken_guess", c_guess, 1);
    if_pc = 32'h80; #1;
    check("alias_guess", c_guess, 1);
    check("br_after2", br_count, 2);
    check("miss_after2", miss_count, 2);
    if_pc = 32'h40; flush = 1;
    tick();
    flush = 0;
    em(1, 1, 0, 32'h100, 0); #1;
    check("pipe_flushed_hit", hit, 1);
    em(0, 0, 0, 0, 0);
    tick();
    em(1, 1, 0, 32'h100, 0); #1;
    check("pipe_lat1_hit", hit, 1);
    em(0, 0, 0, 0, 0);
    tick();
    em(1, 1, 0, 32'h100, 0); #1;
    check("pipe_lat2_hit", hit, 0);
    check("pipe_lat2_eg", em_guess, 0);
    tick();
    check("miss_inc", miss_count, 3);
    check("br_inc", br_count, 3);
    if_pc = 32'h100; stall = 1;
    em(1, 1, 0, 32'h40, 0);
    tick(); tick(); tick();
    check("stall_br", br_count, 3);
    check("stall_pipe_hit", hit, 0);
    if_pc = 32'h40; #1;
    check("stall_tbl", c_guess, 1);
    if_pc = 32'h100;
    em(0, 0, 0, 0, 0); flush = 1;
    tick();
    flush = 0; stall = 0;
    em(1, 1, 0, 32'h40, 0); #1;
    check("flush_over_stall", hit, 1);
    if_pc = 32'h40;
    em(1, 1, 0, 32'h40, 1);
    for (int i = 0; i < 5; i++) tick();
    check("sat_guess", c_guess, 1);
    check("sat_br", br_count, 8);
    check("sat_miss", miss_count, 5);
    em(1, 1, 0, 32'h40, 0);
    tick(); check("nt1_guess", c_guess, 1);
    tick(); check("nt2_guess", c_guess, 0);
    tick(); check("nt3_guess", c_guess, 0);
    tick(); check("nt4_guess", c_guess, 0);
    check("nt_br", br_count, 12);
    check("nt_miss", miss_count, 9);
    em(1, 1, 1, 32'h40, 1); #1;
    check("jalr_type", em_type, 1);
    check("jalr_hit", hit, 1);
    check("jalr_eg", em_guess, 1);
    tick(); tick();
    check("jalr_notrain", c_guess, 0);
    check("jalr_br", br_count, 12);
    check("jalr_miss", miss_count, 9);
    em(1, 1, 0, 32'h40, 1);
    tick(); tick();
    check("retrain_guess", c_guess, 1);
    em(0, 0, 0, 0, 0); rst_n = 0;
    tick();
    rst_n = 1; #1;
    check("rst2_guess", c_guess, 0);
    check("rst2_br", br_count, 0);
    check("rst2_miss", miss_count, 0);
    em(1, 1, 0, 32'h100, 1);
    tick();
    em(0, 0, 0, 0, 0); if_pc = 32'h100; #1;
    check("rst2_init01", c_guess, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
